// File: rtl/lc3_pkg.sv
// Shared definitions for the LC3 control sequencer: opcode codes, the
// controller state encoding and opcode classification helpers.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXECUTE = 4'd3,
        ST_MEM_IND = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_UPDPC   = 4'd7
    } ctrl_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    // LDI/STI need a pointer read before the real data access
    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    // Instructions that finish with a register-file write
    function automatic logic writes_reg(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
               (op == OP_LEA) || is_load(op);
    endfunction

    // JSR, RTI, TRAP and the reserved code are not handled by this sequencer
    function automatic logic is_legal(input logic [3:0] op);
        return writes_reg(op) || is_store(op) || (op == OP_BR) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath plus memories (slave).
interface lc3_ctrl_fsm_if;
    logic       run;
    logic [3:0] opcode;
    logic       imem_ack;
    logic       dmem_ack;
    logic       en_fetch;
    logic       en_decode;
    logic       en_execute;
    logic       en_writeback;
    logic       en_updatepc;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ind;
    logic [3:0] state_o;
    logic       err_timeout;
    logic       illegal_op;

    modport master (
        input  run, opcode, imem_ack, dmem_ack,
        output en_fetch, en_decode, en_execute, en_writeback, en_updatepc,
               imem_req, dmem_req, dmem_we, dmem_ind, state_o,
               err_timeout, illegal_op
    );

    modport slave (
        output run, opcode, imem_ack, dmem_ack,
        input  en_fetch, en_decode, en_execute, en_writeback, en_updatepc,
               imem_req, dmem_req, dmem_we, dmem_ind, state_o,
               err_timeout, illegal_op
    );
endinterface

// File: rtl/lc3_wait_timer.sv
// Memory wait counter shared by all request states; flags the last
// permitted wait cycle.
module lc3_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [CNT_W-1:0] r_count;

    // Count waiting cycles; clear wins so each new state starts from zero
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC3 multi-cycle control sequencer: fetch, decode, execute, memory,
// write-back and PC update, with bounded memory handshakes.
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    lc3_ctrl_fsm_if.master     bus
);
    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    logic [3:0]  r_opcode;
    logic        w_waiting;
    logic        w_ack;
    logic        w_expired;
    logic        w_timeout;

    // Only the state that issued a request listens to its ack
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM) ||
                       (r_state == ST_MEM_IND);
    assign w_ack     = (r_state == ST_FETCH) ? bus.imem_ack :
                       ((r_state == ST_MEM) || (r_state == ST_MEM_IND)) ? bus.dmem_ack :
                       1'b0;
    // An ack on the final allowed cycle still wins over the abort
    assign w_timeout = w_waiting && !w_ack && w_expired;

    lc3_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_state_next != r_state),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack)  w_state_next = ST_DECODE;
                else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_DECODE: begin
                w_state_next = is_legal(bus.opcode) ? ST_EXECUTE : ST_UPDPC;
            end
            ST_EXECUTE: begin
                if (is_indirect(r_opcode))
                    w_state_next = ST_MEM_IND;
                else if (is_load(r_opcode) || is_store(r_opcode))
                    w_state_next = ST_MEM;
                else if (writes_reg(r_opcode))
                    w_state_next = ST_WB;
                else
                    w_state_next = ST_UPDPC;
            end
            ST_MEM_IND: begin
                if (bus.dmem_ack)   w_state_next = ST_MEM;
                else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_MEM: begin
                if (bus.dmem_ack)   w_state_next = is_load(r_opcode) ? ST_WB : ST_UPDPC;
                else if (w_timeout) w_state_next = ST_IDLE;
            end
            ST_WB:    w_state_next = ST_UPDPC;
            ST_UPDPC: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register and opcode latch; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_DECODE) r_opcode <= bus.opcode;
        end
    end

    // Stage enables and requests decoded from the state register
    always_comb begin
        bus.en_fetch     = (r_state == ST_FETCH) && bus.imem_ack;
        bus.en_decode    = (r_state == ST_DECODE);
        bus.en_execute   = (r_state == ST_EXECUTE);
        bus.en_writeback = (r_state == ST_WB);
        bus.en_updatepc  = (r_state == ST_UPDPC);
        bus.imem_req     = (r_state == ST_FETCH);
        bus.dmem_req     = (r_state == ST_MEM) || (r_state == ST_MEM_IND);
        bus.dmem_we      = (r_state == ST_MEM) && is_store(r_opcode);
        bus.dmem_ind     = (r_state == ST_MEM) && is_indirect(r_opcode);
        bus.state_o      = r_state;
        bus.err_timeout  = w_timeout;
        bus.illegal_op   = (r_state == ST_DECODE) && !is_legal(bus.opcode);
    end
endmodule
